// File: rtl/cs_seq_pkg.sv
// rtl/cs_seq_pkg.sv - shared op encodings and default sizes for the microprogram sequencer
package cs_seq_pkg;

    localparam int SEQ_DEFAULT_ADDR_W = 11;
    localparam int SEQ_DEFAULT_DEPTH  = 4;

    localparam logic [2:0] SEQ_OP_NEXT   = 3'd0;
    localparam logic [2:0] SEQ_OP_JUMP   = 3'd1;
    localparam logic [2:0] SEQ_OP_JCOND  = 3'd2;
    localparam logic [2:0] SEQ_OP_CALL   = 3'd3;
    localparam logic [2:0] SEQ_OP_RET    = 3'd4;
    localparam logic [2:0] SEQ_OP_JNCOND = 3'd5;

endpackage

// File: rtl/cs_seq_stack.sv
// rtl/cs_seq_stack.sv - LIFO return-address stack; only the level is reset
module cs_seq_stack
    import cs_seq_pkg::*;
#(
    parameter int DEPTH   = SEQ_DEFAULT_DEPTH,
    parameter int WIDTH   = SEQ_DEFAULT_ADDR_W,
    parameter int LEVEL_W = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               push,
    input  logic               pop,
    input  logic [WIDTH-1:0]   push_data,
    output logic [WIDTH-1:0]   top_data,
    output logic [LEVEL_W-1:0] level,
    output logic               full,
    output logic               empty
);

    logic [WIDTH-1:0]   mem_q [DEPTH];
    logic [WIDTH-1:0]   mem_d [DEPTH];
    logic [LEVEL_W-1:0] level_q;
    logic [LEVEL_W-1:0] level_d;

    assign full  = (level_q == LEVEL_W'(DEPTH));
    assign empty = (level_q == '0);
    assign level = level_q;

    // Top of stack is the entry just below the level pointer; compare-select avoids an oversized index.
    always_comb begin
        top_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (level_q == LEVEL_W'(i + 1)) begin
                top_data = mem_q[i];
            end
        end
    end

    // Next contents and level: push writes at the level pointer, pop just moves the pointer down.
    always_comb begin
        level_d = level_q;
        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = mem_q[i];
        end
        if (push && !full) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (level_q == LEVEL_W'(i)) begin
                    mem_d[i] = push_data;
                end
            end
            level_d = level_q + LEVEL_W'(1);
        end else if (pop && !empty) begin
            level_d = level_q - LEVEL_W'(1);
        end
    end

    // Entries keep stale data across reset; the level alone marks what is valid.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= mem_d[i];
        end
        if (rst) begin
            level_q <= '0;
        end else begin
            level_q <= level_d;
        end
    end

endmodule

// File: rtl/cs_sequencer.sv
// rtl/cs_sequencer.sv - control-store uPC sequencer with call/return stack and sticky misuse flag
module cs_sequencer
    import cs_seq_pkg::*;
#(
    parameter int SEQ_LENGTH_ADDR = SEQ_DEFAULT_ADDR_W,
    parameter int SEQ_STACK_DEPTH = SEQ_DEFAULT_DEPTH,
    parameter int SEQ_RESET_ADDR  = 0,
    parameter int SEQ_LEVEL_W     = $clog2(SEQ_STACK_DEPTH + 1)
) (
    input  logic                       CS_SEQ_CLOCK_50,
    input  logic                       CS_SEQ_RESET,
    input  logic [2:0]                 CS_SEQ_OP,
    input  logic [SEQ_LENGTH_ADDR-1:0] CS_SEQ_JUMP_ADDR,
    input  logic                       CS_SEQ_COND,
    input  logic                       CS_SEQ_ACK,
    output logic [SEQ_LENGTH_ADDR-1:0] CS_SEQ_ADDR_OutBUS,
    output logic [SEQ_LEVEL_W-1:0]     CS_SEQ_STACK_LEVEL,
    output logic                       CS_SEQ_STACK_ERR
);

    logic [SEQ_LENGTH_ADDR-1:0] upc_q;
    logic [SEQ_LENGTH_ADDR-1:0] upc_d;
    logic                       err_q;
    logic                       err_d;
    logic [SEQ_LENGTH_ADDR-1:0] upc_inc;
    logic                       stk_push;
    logic                       stk_pop;
    logic [SEQ_LENGTH_ADDR-1:0] stk_top;
    logic                       stk_full;
    logic                       stk_empty;

    // Wraps naturally at the address width.
    assign upc_inc = upc_q + SEQ_LENGTH_ADDR'(1);

    cs_seq_stack #(
        .DEPTH   (SEQ_STACK_DEPTH),
        .WIDTH   (SEQ_LENGTH_ADDR),
        .LEVEL_W (SEQ_LEVEL_W)
    ) u_stack (
        .clk       (CS_SEQ_CLOCK_50),
        .rst       (CS_SEQ_RESET),
        .push      (stk_push),
        .pop       (stk_pop),
        .push_data (upc_inc),
        .top_data  (stk_top),
        .level     (CS_SEQ_STACK_LEVEL),
        .full      (stk_full),
        .empty     (stk_empty)
    );

    // Next-address select; with ACK low nothing moves and the inputs are ignored.
    always_comb begin
        upc_d    = upc_q;
        err_d    = err_q;
        stk_push = 1'b0;
        stk_pop  = 1'b0;
        if (CS_SEQ_ACK) begin
            case (CS_SEQ_OP)
                SEQ_OP_JUMP: begin
                    upc_d = CS_SEQ_JUMP_ADDR;
                end
                SEQ_OP_JCOND: begin
                    upc_d = CS_SEQ_COND ? CS_SEQ_JUMP_ADDR : upc_inc;
                end
                SEQ_OP_JNCOND: begin
                    upc_d = CS_SEQ_COND ? upc_inc : CS_SEQ_JUMP_ADDR;
                end
                SEQ_OP_CALL: begin
                    if (!stk_full) begin
                        stk_push = 1'b1;
                        upc_d    = CS_SEQ_JUMP_ADDR;
                    end else begin
                        upc_d = upc_inc;
                        err_d = 1'b1;
                    end
                end
                SEQ_OP_RET: begin
                    if (!stk_empty) begin
                        stk_pop = 1'b1;
                        upc_d   = stk_top;
                    end else begin
                        upc_d = upc_inc;
                        err_d = 1'b1;
                    end
                end
                default: begin
                    upc_d = upc_inc;
                end
            endcase
        end
    end

    // uPC and sticky error register; reset overrides ACK and OP.
    always_ff @(posedge CS_SEQ_CLOCK_50) begin
        if (CS_SEQ_RESET) begin
            upc_q <= SEQ_LENGTH_ADDR'(SEQ_RESET_ADDR);
            err_q <= 1'b0;
        end else begin
            upc_q <= upc_d;
            err_q <= err_d;
        end
    end

    assign CS_SEQ_ADDR_OutBUS = upc_q;
    assign CS_SEQ_STACK_ERR   = err_q;

endmodule

// File: tb/tb_cs_sequencer.sv
// tb/tb_cs_sequencer.sv - scoreboard bench for cs_sequencer using directed vectors
module tb_cs_sequencer;

    localparam logic [2:0] OP_NEXT   = 3'd0;
    localparam logic [2:0] OP_JUMP   = 3'd1;
    localparam logic [2:0] OP_JCOND  = 3'd2;
    localparam logic [2:0] OP_CALL   = 3'd3;
    localparam logic [2:0] OP_RET    = 3'd4;
    localparam logic [2:0] OP_JNCOND = 3'd5;

    typedef struct packed {
        logic [10:0] addr;
        logic [2:0]  level;
        logic        err;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [2:0]  op;
    logic [10:0] jaddr;
    logic        cond;
    logic        ack;
    logic [10:0] addr_out;
    logic [2:0]  level_out;
    logic        err_out;

    exp_t exp_q[$];
    int   n_cmp;
    int   n_bad;

    cs_sequencer dut (
        .CS_SEQ_CLOCK_50    (clk),
        .CS_SEQ_RESET       (rst),
        .CS_SEQ_OP          (op),
        .CS_SEQ_JUMP_ADDR   (jaddr),
        .CS_SEQ_COND        (cond),
        .CS_SEQ_ACK         (ack),
        .CS_SEQ_ADDR_OutBUS (addr_out),
        .CS_SEQ_STACK_LEVEL (level_out),
        .CS_SEQ_STACK_ERR   (err_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply one cycle of inputs, then queue the state expected after that edge.
    task automatic step(input logic r, input logic a, input logic [2:0] o,
                        input logic [10:0] j, input logic c,
                        input logic [10:0] e_addr, input logic [2:0] e_lvl, input logic e_err);
        exp_t e;
        rst   = r;
        ack   = a;
        op    = o;
        jaddr = j;
        cond  = c;
        @(posedge clk);
        #1;
        e.addr  = e_addr;
        e.level = e_lvl;
        e.err   = e_err;
        exp_q.push_back(e);
    endtask

    // Monitor: on the falling edge, check the DUT against the oldest pending expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_cmp++;
                if (addr_out !== e.addr) begin
                    n_bad++;
                    $display("FAIL addr: got %03h expected %03h", addr_out, e.addr);
                end
                n_cmp++;
                if (level_out !== e.level) begin
                    n_bad++;
                    $display("FAIL level: got %0d expected %0d (addr %03h)", level_out, e.level, e.addr);
                end
                n_cmp++;
                if (err_out !== e.err) begin
                    n_bad++;
                    $display("FAIL err: got %0b expected %0b (addr %03h)", err_out, e.err, e.addr);
                end
            end
        end
    end

    initial begin
        int waited;
        n_cmp = 0;
        n_bad = 0;
        rst = 1'b1; ack = 1'b0; op = OP_NEXT; jaddr = '0; cond = 1'b0;

        // reset, increment and wrap
        step(1, 0, OP_NEXT,   11'h000, 0, 11'h000, 0, 0);
        step(0, 1, OP_NEXT,   11'h000, 0, 11'h001, 0, 0);
        step(0, 1, OP_NEXT,   11'h000, 0, 11'h002, 0, 0);
        step(0, 1, OP_NEXT,   11'h000, 0, 11'h003, 0, 0);
        step(0, 1, OP_JUMP,   11'h7FF, 0, 11'h7FF, 0, 0);
        step(0, 1, OP_NEXT,   11'h000, 0, 11'h000, 0, 0);

        // conditional jumps and reserved ops
        step(0, 1, OP_JUMP,   11'h010, 0, 11'h010, 0, 0);
        step(0, 1, OP_JCOND,  11'h200, 0, 11'h011, 0, 0);
        step(0, 1, OP_JCOND,  11'h200, 1, 11'h200, 0, 0);
        step(0, 1, OP_JNCOND, 11'h300, 0, 11'h300, 0, 0);
        step(0, 1, OP_JNCOND, 11'h3AA, 1, 11'h301, 0, 0);
        step(0, 1, 3'd6,      11'h555, 1, 11'h302, 0, 0);
        step(0, 1, 3'd7,      11'h555, 0, 11'h303, 0, 0);

        // simple call / return
        step(0, 1, OP_JUMP,   11'h020, 0, 11'h020, 0, 0);
        step(0, 1, OP_CALL,   11'h100, 0, 11'h100, 1, 0);
        step(0, 1, OP_NEXT,   11'h000, 0, 11'h101, 1, 0);
        step(0, 1, OP_RET,    11'h000, 0, 11'h021, 0, 0);

        // nested calls, overflow, LIFO unwind, underflow
        step(0, 1, OP_JUMP,   11'h040, 0, 11'h040, 0, 0);
        step(0, 1, OP_CALL,   11'h080, 0, 11'h080, 1, 0);
        step(0, 1, OP_CALL,   11'h090, 0, 11'h090, 2, 0);
        step(0, 1, OP_CALL,   11'h0A0, 0, 11'h0A0, 3, 0);
        step(0, 1, OP_CALL,   11'h050, 0, 11'h050, 4, 0);
        step(0, 1, OP_CALL,   11'h400, 0, 11'h051, 4, 1);
        step(0, 1, OP_RET,    11'h000, 0, 11'h0A1, 3, 1);
        step(0, 1, OP_RET,    11'h000, 0, 11'h091, 2, 1);
        step(0, 1, OP_RET,    11'h000, 0, 11'h081, 1, 1);
        step(0, 1, OP_RET,    11'h000, 0, 11'h041, 0, 1);
        step(0, 1, OP_RET,    11'h000, 0, 11'h042, 0, 1);

        // stall holds everything
        step(0, 1, OP_CALL,   11'h200, 0, 11'h200, 1, 1);
        step(0, 1, OP_CALL,   11'h210, 0, 11'h210, 2, 1);
        step(0, 0, OP_JUMP,   11'h123, 0, 11'h210, 2, 1);
        step(0, 0, OP_JUMP,   11'h123, 1, 11'h210, 2, 1);
        step(0, 0, OP_RET,    11'h123, 0, 11'h210, 2, 1);
        step(0, 1, OP_JUMP,   11'h123, 0, 11'h123, 2, 1);

        // reset mid-chain discards the stack
        step(1, 0, OP_NEXT,   11'h000, 0, 11'h000, 0, 0);
        step(0, 1, OP_RET,    11'h000, 0, 11'h001, 0, 1);
        step(1, 1, OP_JUMP,   11'h555, 0, 11'h000, 0, 0);
        step(0, 1, OP_CALL,   11'h333, 0, 11'h333, 1, 0);
        step(0, 1, OP_RET,    11'h000, 0, 11'h001, 0, 0);

        ack = 1'b0;
        waited = 0;
        while (exp_q.size() > 0 && waited < 20) begin
            @(posedge clk);
            waited++;
        end
        @(posedge clk);
        if (exp_q.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/cs_sequencer.md
# cs_sequencer

Microprogram sequencer for the control-store path: holds the current control-store address (uPC) and, on each acknowledged cycle, selects the next address from increment, unconditional/conditional jump, subroutine call, or return. It is the address-consuming end of the control-store interface and produces the address bus that indexes the control-store ROM. A small LIFO return stack supports nested microsubroutines. A sticky error flag reports stack misuse.

## Interface
- SEQ_LENGTH_ADDR, 11, control-store address width
- SEQ_STACK_DEPTH, 4, return-stack entries (≥1)
- SEQ_RESET_ADDR, 0, uPC value after reset
- SEQ_LEVEL_W, $clog2(SEQ_STACK_DEPTH+1), width of stack level output
- CS_SEQ_CLOCK_50  input  1  single clock; all state updates on rising edge
- CS_SEQ_RESET  input  1  reset, synchronous and active-high
- CS_SEQ_OP  input  3  sequence field of current microinstruction
- CS_SEQ_JUMP_ADDR  input  SEQ_LENGTH_ADDR  branch/call target
- CS_SEQ_COND  input  1  pre-selected condition flag
- CS_SEQ_ACK  input  1  datapath ready; 0 stalls the sequencer
- CS_SEQ_ADDR_OutBUS  output  SEQ_LENGTH_ADDR  current uPC (registered)
- CS_SEQ_STACK_LEVEL  output  SEQ_LEVEL_W  number of valid stack entries
- CS_SEQ_STACK_ERR  output  1  sticky overflow/underflow flag

## Operation
- Op encoding: 0 NEXT, 1 JUMP, 2 JCOND (jump if COND=1), 3 CALL, 4 RET, 5 JNCOND (jump if COND=0), 6–7 treated as NEXT.
- inc = uPC + 1, modulo 2^SEQ_LENGTH_ADDR (0x7FF + 1 = 0x000 at default width).
- ACK=1, per op:
  - NEXT: uPC <= inc.
  - JUMP: uPC <= JUMP_ADDR.
  - JCOND/JNCOND: uPC <= JUMP_ADDR if condition met, else inc.
  - CALL, level < DEPTH: push inc, level+1, uPC <= JUMP_ADDR.
  - CALL, level = DEPTH (full): no push, level unchanged, uPC <= inc, ERR <= 1.
  - RET, level > 0: uPC <= top entry, level−1.
  - RET, level = 0 (empty): uPC <= inc, ERR <= 1.
- ACK=0: uPC, stack contents, level and ERR all hold; OP/COND/JUMP_ADDR ignored.
- ERR clears only on reset.
- Stack entries are not cleared on reset; only level resets. Entries above level are don't-care.

## Timing
- Reset (sampled on clock edge, dominates ACK and OP): ADDR_OutBUS = SEQ_RESET_ADDR, STACK_LEVEL = 0, STACK_ERR = 0, effective the cycle after the edge.
- Latency: OP sampled at edge N with ACK=1 → new address on ADDR_OutBUS after edge N; one microinstruction per acknowledged cycle.
- All outputs registered; no combinational path from inputs to outputs.
- STACK_LEVEL and STACK_ERR update on the same edge as uPC.
- Reset asserted mid-call-chain: stack discarded, level 0; next RET underflows.
- COND sampled only when ACK=1 and op is JCOND/JNCOND.

## Structure
- Package cs_seq_pkg: op encodings (SEQ_OP_NEXT … SEQ_OP_JNCOND), default address width and stack depth constants.
- Sub-module cs_seq_stack: LIFO of SEQ_STACK_DEPTH × SEQ_LENGTH_ADDR, push/pop/level/full/empty, synchronous reset of level only.
- Top holds uPC register, incrementer, next-address mux and sticky ERR.

## Test plan
- Reset then 3× NEXT with ACK=1 → ADDR 0x000, 0x001, 0x002, 0x003; ADDR at 0x7FF + NEXT → 0x000.
- uPC=0x010, JCOND target 0x200 COND=0 → 0x011; JCOND COND=1 → 0x200; JNCOND COND=0 target 0x300 → 0x300.
- uPC=0x020 CALL 0x100 → ADDR 0x100, LEVEL 1; NEXT → 0x101; RET → 0x021, LEVEL 0, ERR 0.
- 4 nested CALLs then 5th CALL 0x400 from 0x050 → ADDR 0x051, LEVEL 4, ERR 1; 4 RETs unwind in LIFO order; 5th RET → inc, ERR stays 1.
- ACK=0 for 3 cycles with JUMP 0x123 on OP → ADDR, LEVEL, ERR unchanged; ACK=1 → ADDR 0x123.
- Reset asserted with LEVEL 2, ERR 1, ACK=0 → next cycle ADDR 0x000, LEVEL 0, ERR 0; immediate RET → ERR 1.
